// File: rtl/chip2chip_pkg.sv
// Shared definitions for the chip-to-chip link: FSM encodings and
// default word width / cycle constants used by both board sides.
package chip2chip_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ACK     = 2'b01,
    S_RELEASE = 2'b10
  } state_e;

  localparam int unsigned DATA_W_DEF      = 3;
  localparam int unsigned NOTICE_CYC_DEF  = 100_000_000;
  localparam int unsigned TIMEOUT_CYC_DEF = 200_000_000;

endpackage

// File: rtl/slave_control_if.sv
// Handshake and data bundle between the master header pins and the slave board.
// The master modport drives the link lines; the slave modport answers them.
interface slave_control_if
  import chip2chip_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              request;
  logic              valid;
  logic [DATA_W-1:0] data_in;
  logic              ack;
  logic              notice;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              timeout;

  modport master (
    output request, valid, data_in,
    input  ack, notice, data_out, data_valid, timeout
  );

  modport slave (
    input  request, valid, data_in,
    output ack, notice, data_out, data_valid, timeout
  );

endinterface

// File: rtl/pulse_timer.sv
// Retriggerable cycle timer: busy stays high for exactly CYC cycles after start,
// done flags the final busy cycle. The count saturates instead of wrapping.
module pulse_timer #(
  parameter int unsigned CYC = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(CYC + 1);

  logic [CNT_W-1:0] count_q;
  logic             busy_q;

  // A start always reloads, so a retrigger while running restarts the full window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      count_q <= CNT_W'(1);
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      if (count_q == CNT_W'(CYC)) begin
        busy_q <= 1'b0;
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (count_q == CNT_W'(CYC));

endmodule

// File: rtl/slave_control.sv
// Slave side of the chip-to-chip handshake: synchronizes the link lines, answers
// request/ack/valid and captures the word. Optional S_ACK abort: SLAVE_TIMEOUT_EN.
module slave_control
  import chip2chip_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned NOTICE_CYC  = NOTICE_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  slave_control_if.slave bus
);

  logic              reqMeta_q, reqSync_q;
  logic              validMeta_q, validSync_q;
  logic [DATA_W-1:0] dataMeta_q, dataSync_q;

  state_e            state_q;
  logic              ack_q;
  logic [DATA_W-1:0] dataOut_q;
  logic              dataValid_q;
  logic              acceptReq;
  logic              noticeBusy;
  logic              unusedNoticeDone;

  // Data shares the valid path's two stages so both arrive on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reqMeta_q   <= 1'b0;
      reqSync_q   <= 1'b0;
      validMeta_q <= 1'b0;
      validSync_q <= 1'b0;
      dataMeta_q  <= '0;
      dataSync_q  <= '0;
    end else begin
      reqMeta_q   <= bus.request;
      reqSync_q   <= reqMeta_q;
      validMeta_q <= bus.valid;
      validSync_q <= validMeta_q;
      dataMeta_q  <= bus.data_in;
      dataSync_q  <= dataMeta_q;
    end
  end

  assign acceptReq = (state_q == S_IDLE) && reqSync_q && !validSync_q;

  pulse_timer #(.CYC(NOTICE_CYC)) u_notice_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (acceptReq),
    .busy  (noticeBusy),
    .done  (unusedNoticeDone)
  );

`ifdef SLAVE_TIMEOUT_EN
  logic timeout_q;
  logic timeoutDone;
  logic unusedTimeoutBusy;

  pulse_timer #(.CYC(TIMEOUT_CYC)) u_timeout_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (acceptReq),
    .busy  (unusedTimeoutBusy),
    .done  (timeoutDone)
  );

  assign bus.timeout = timeout_q;
`else
  localparam int unsigned unusedTimeoutCyc = TIMEOUT_CYC;

  assign bus.timeout = 1'b0;
`endif

  // An abort still passes through S_RELEASE so a late valid cannot be re-accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ack_q       <= 1'b0;
      dataOut_q   <= '0;
      dataValid_q <= 1'b0;
`ifdef SLAVE_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      dataValid_q <= 1'b0;
`ifdef SLAVE_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (acceptReq) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
          end
        end
        S_ACK: begin
          if (validSync_q) begin
            dataOut_q   <= dataSync_q;
            dataValid_q <= 1'b1;
            ack_q       <= 1'b0;
            state_q     <= S_RELEASE;
          end
`ifdef SLAVE_TIMEOUT_EN
          else if (timeoutDone) begin
            ack_q     <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= S_RELEASE;
          end
`endif
        end
        S_RELEASE: begin
          if (!validSync_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack        = ack_q;
  assign bus.notice     = noticeBusy;
  assign bus.data_out   = dataOut_q;
  assign bus.data_valid = dataValid_q;

endmodule

// File: tb/tb_slave_control.sv
// Directed bench for slave_control with short notice/timeout windows;
// the timeout scenarios follow SLAVE_TIMEOUT_EN like the RTL does.
module tb_slave_control;
  import chip2chip_pkg::*;

  localparam int unsigned DW = 3;
  localparam int unsigned NC = 10;
  localparam int unsigned TC = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  slave_control_if #(.DATA_W(DW)) bus ();

  slave_control #(
    .DATA_W      (DW),
    .NOTICE_CYC  (NC),
    .TIMEOUT_CYC (TC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checkCount = 0;
  int errorCount = 0;
  int ackSeen, dvSeen, noticeSeen, toSeen, consecutive;
  logic prevDv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic vld, input logic [DW-1:0] word);
    bus.request = req;
    bus.valid   = vld;
    bus.data_in = word;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitAck(input logic level, input string tag);
    int n;
    n = 0;
    while (bus.ack !== level && n < 20) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(bus.ack), 32'(level));
  endtask

  task automatic waitDataValid(input string tag);
    int n;
    n = 0;
    while (bus.data_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(bus.data_valid), 32'd1);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, '0);
    rst_n = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("rst_ack",        32'(bus.ack),        32'd0);
    checkOutput("rst_notice",     32'(bus.notice),     32'd0);
    checkOutput("rst_data_out",   32'(bus.data_out),   32'd0);
    checkOutput("rst_data_valid", 32'(bus.data_valid), 32'd0);
    checkOutput("rst_timeout",    32'(bus.timeout),    32'd0);
    checkOutput("rst_state",      32'(dut.state_q),    32'(S_IDLE));
    rst_n = 1'b1;
    tick();

    // Valid without a request must be ignored entirely.
    applyStimulus(1'b0, 1'b1, 3'b111);
    ackSeen = 0;
    dvSeen  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      ackSeen += int'(bus.ack);
      dvSeen  += int'(bus.data_valid);
    end
    checkOutput("spur_ack",      32'(ackSeen),         32'd0);
    checkOutput("spur_dv",       32'(dvSeen),          32'd0);
    checkOutput("spur_data_out", 32'(bus.data_out),    32'd0);
    applyStimulus(1'b0, 1'b0, '0);
    repeat (4) tick();

    // Full handshake with the master's relaxed timing.
    applyStimulus(1'b1, 1'b0, '0);
    tick();
    tick();
    checkOutput("hs_ack_early",  32'(bus.ack),    32'd0);
    tick();
    checkOutput("hs_ack_rise",   32'(bus.ack),    32'd1);
    checkOutput("hs_notice_rise", 32'(bus.notice), 32'd1);
    noticeSeen = 1;
    dvSeen     = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 5) applyStimulus(1'b0, 1'b0, '0);
      noticeSeen += int'(bus.notice);
      dvSeen     += int'(bus.data_valid);
      if (i == int'(NC)) checkOutput("hs_notice_fall", 32'(bus.notice), 32'd0);
    end
    checkOutput("hs_notice_len", 32'(noticeSeen), 32'(NC));
    checkOutput("hs_ack_hold",   32'(bus.ack),    32'd1);
    checkOutput("hs_no_dv",      32'(dvSeen),     32'd0);
    applyStimulus(1'b0, 1'b1, 3'b101);
    tick();
    tick();
    checkOutput("hs_dv_early",  32'(bus.data_valid), 32'd0);
    checkOutput("hs_ack_still", 32'(bus.ack),        32'd1);
    tick();
    checkOutput("hs_data_out",  32'(bus.data_out),   32'h5);
    checkOutput("hs_dv_pulse",  32'(bus.data_valid), 32'd1);
    checkOutput("hs_ack_fall",  32'(bus.ack),        32'd0);
    tick();
    checkOutput("hs_dv_single", 32'(bus.data_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 3'b101);
    tick();
    tick();
    checkOutput("hs_state_rel",  32'(dut.state_q), 32'(S_RELEASE));
    tick();
    checkOutput("hs_state_idle", 32'(dut.state_q), 32'(S_IDLE));

    // Back-to-back transfers; the second request goes up as valid drops.
    applyStimulus(1'b1, 1'b0, 3'b011);
    waitAck(1'b1, "b2b_ack1");
    applyStimulus(1'b0, 1'b1, 3'b011);
    waitDataValid("b2b_dv1");
    checkOutput("b2b_data1", 32'(bus.data_out), 32'h3);
    dvSeen = int'(bus.data_valid);
    applyStimulus(1'b1, 1'b0, 3'b110);
    waitAck(1'b1, "b2b_ack2");
    applyStimulus(1'b0, 1'b1, 3'b110);
    noticeSeen  = int'(bus.notice);
    prevDv      = bus.data_valid;
    consecutive = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 4) applyStimulus(1'b0, 1'b0, 3'b110);
      noticeSeen += int'(bus.notice);
      dvSeen     += int'(bus.data_valid);
      if (bus.data_valid && prevDv) consecutive++;
      prevDv = bus.data_valid;
    end
    checkOutput("b2b_dv_count",   32'(dvSeen),       32'd2);
    checkOutput("b2b_data2",      32'(bus.data_out), 32'h6);
    checkOutput("b2b_notice_len", 32'(noticeSeen),   32'(NC));
    checkOutput("b2b_dv_consec",  32'(consecutive),  32'd0);
    repeat (4) tick();

`ifdef SLAVE_TIMEOUT_EN
    // Accepted request with no valid: abort after TC cycles in S_ACK.
    applyStimulus(1'b1, 1'b0, '0);
    waitAck(1'b1, "to_ack");
    ackSeen = 1;
    toSeen  = 0;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (i == 1) applyStimulus(1'b0, 1'b0, '0);
      ackSeen += int'(bus.ack);
      toSeen  += int'(bus.timeout);
      if (i == int'(TC)) begin
        checkOutput("to_pulse",    32'(bus.timeout), 32'd1);
        checkOutput("to_ack_fall", 32'(bus.ack),     32'd0);
      end
    end
    checkOutput("to_ack_len",   32'(ackSeen),      32'(TC));
    checkOutput("to_count",     32'(toSeen),       32'd1);
    checkOutput("to_data_hold", 32'(bus.data_out), 32'h6);

    // Valid reaches the FSM on the expiry edge: capture wins.
    applyStimulus(1'b1, 1'b0, '0);
    waitAck(1'b1, "race_ack");
    toSeen = 0;
    dvSeen = 0;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (i == 1) applyStimulus(1'b0, 1'b0, 3'b001);
      if (i == int'(TC) - 3) applyStimulus(1'b0, 1'b1, 3'b001);
      if (i == int'(TC) + 3) applyStimulus(1'b0, 1'b0, 3'b001);
      if (i == int'(TC)) checkOutput("race_dv", 32'(bus.data_valid), 32'd1);
      toSeen += int'(bus.timeout);
      dvSeen += int'(bus.data_valid);
    end
    checkOutput("race_no_to",   32'(toSeen),       32'd0);
    checkOutput("race_dv_cnt",  32'(dvSeen),       32'd1);
    checkOutput("race_data",    32'(bus.data_out), 32'h1);
    repeat (4) tick();
`else
    // Without the abort, S_ACK holds ack indefinitely.
    applyStimulus(1'b1, 1'b0, '0);
    waitAck(1'b1, "hold_ack");
    ackSeen = 0;
    toSeen  = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (i == 5) applyStimulus(1'b0, 1'b0, '0);
      ackSeen += int'(!bus.ack);
      toSeen  += int'(bus.timeout);
    end
    checkOutput("hold_ack_low", 32'(ackSeen), 32'd0);
    checkOutput("hold_no_to",   32'(toSeen),  32'd0);
`endif

    // Reset while in S_ACK clears everything on the next edge.
    applyStimulus(1'b1, 1'b0, '0);
    waitAck(1'b1, "mid_ack");
    applyStimulus(1'b0, 1'b0, '0);
    rst_n = 1'b0;
    tick();
    checkOutput("mid_ack_clr",    32'(bus.ack),      32'd0);
    checkOutput("mid_notice_clr", 32'(bus.notice),   32'd0);
    checkOutput("mid_data_clr",   32'(bus.data_out), 32'd0);
    checkOutput("mid_state_idle", 32'(dut.state_q),  32'(S_IDLE));
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/slave_control.md
# slave_control

Slave-side control block for the two-board chip-to-chip link. It answers the master's request/ack/valid handshake and synchronizes the off-chip request, valid and data lines into the local clock domain. It captures the transferred word and shows a 1-second notice when a request is accepted. It sits between the inter-board header pins and the slave board's display/LED logic.

## Interface
- DATA_W, 3, width of the transferred data word
- NOTICE_CYC, 100_000_000, cycles `notice` stays high after a request is accepted (1 s at 100 MHz)
- TIMEOUT_CYC, 200_000_000, cycles to wait for `valid` before aborting; used only with SLAVE_TIMEOUT_EN
- clk  input  1  system clock; all logic on posedge
- rst_n  input  1  synchronous, active-low reset
- request  input  1  request line from the master, asynchronous to clk
- valid  input  1  data-valid line from the master, asynchronous
- data_in  input  DATA_W  data lines from the master, asynchronous; stable while `valid` is high
- ack  output  1  acknowledge line to the master
- notice  output  1  LED drive, high for NOTICE_CYC cycles after a request is accepted
- data_out  output  DATA_W  last captured word; holds until the next capture
- data_valid  output  1  one-cycle pulse on each capture
- timeout  output  1  one-cycle pulse on a handshake abort; constant 0 when the feature is compiled out

## Operation
- Input sync: `request`, `valid` and `data_in` each pass through a 2-flop synchronizer, giving `request_s`, `valid_s` and `data_s`. `data_s` uses the same two stages as `valid_s`, so the two stay aligned.
- S_IDLE (reset state)
  - ack=0.
  - If request_s=1 and valid_s=0: go to S_ACK, set ack←1, start the notice timer.
  - If valid_s=1 without a request, ignore it and stay in S_IDLE.
- S_ACK
  - ack=1. The master drops `request` after it sees ack; this has no effect here.
  - If valid_s=1: data_out←data_s, data_valid pulses, ack←0, go to S_RELEASE.
- S_RELEASE
  - ack=0; wait for the master to drop valid.
  - If valid_s=0: go to S_IDLE.
- Notice timer
  - Runs independently of the FSM. `notice` goes high on the same edge ack rises and stays high for exactly NOTICE_CYC cycles.
  - A new acceptance while the timer is running restarts the count.
- Counter widths: timer counters use $clog2(max count + 1) bits. They saturate at terminal count and do not wrap.

## Timing
- Reset values: ack=0, notice=0, data_out=0, data_valid=0, timeout=0, state=S_IDLE, synchronizers=0, counters=0.
- A reset mid-transfer aborts the transfer immediately; there is no partial capture.
- Latency from a `request` pin edge to `ack` high: 3 clk (2 sync stages + 1 register).
- Latency from a `valid` pin edge to data_out update, the data_valid pulse and `ack` low: 3 clk, all on the same edge.
- From `valid` falling at the pin to S_IDLE: 3 clk.
- The next request can be accepted on the cycle after S_IDLE is entered.
- data_valid is never high for two consecutive cycles.

## Configuration
- SLAVE_TIMEOUT_EN defined:
  - In S_ACK, a counter runs from entry.
  - If valid_s has not been seen when it reaches TIMEOUT_CYC: ack←0, timeout pulses for 1 cycle, go to S_RELEASE. This prevents re-acceptance while a late valid is still high.
  - data_out is unchanged on a timeout.
  - If valid_s=1 on the same cycle the counter expires, valid wins: normal capture, no timeout.
- SLAVE_TIMEOUT_EN undefined: S_ACK waits indefinitely, timeout is tied to 0, and the timeout counter is not built.

## Structure
- Shared package chip2chip_pkg holds:
  - state encodings S_IDLE=2'b00, S_ACK=2'b01, S_RELEASE=2'b10 (2'b11 is illegal and decodes to S_IDLE)
  - default DATA_W
  - default cycle constants, shared with the master side
- One sub-module, pulse_timer (parameter CYC; ports start, busy, done), instantiated for the notice timer and, under the macro, for the timeout counter.

## Test plan
Sim values: NOTICE_CYC=10, TIMEOUT_CYC=40.
- Full handshake: raise request, lower it 5 cycles after ack rises, set data_in=3'b101 and raise valid 20 cycles later, drop valid once ack falls.
  - Expect ack rises 3 clk after request.
  - Expect notice high for exactly 10 cycles.
  - Expect data_out=3'b101 with a 1-cycle data_valid pulse 3 clk after valid rises, ack low on the same edge.
  - Expect state S_IDLE 3 clk after valid falls.
- Spurious valid: valid=1 with no request for 20 cycles → ack stays 0, no data_valid, data_out stays 0.
- Back-to-back: transfer 3'b011 and then 3'b110 with minimum spacing → two data_valid pulses, data_out ends at 3'b110, notice restarts on the second acceptance.
- Reset mid-transfer: assert rst_n=0 while in S_ACK → on the next edge ack=0, notice=0, data_out=0, state S_IDLE.
- Timeout (macro on): request accepted, valid never raised → after 40 cycles timeout pulses, ack falls, data_out unchanged.
- Timeout race (macro on): raising valid so valid_s=1 on the expiry cycle gives a capture with no timeout pulse.
- Macro off: the same no-valid stimulus keeps ack=1 for 200 cycles with timeout=0.
